// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide memory port between the I-cache and
// D-cache miss paths. One line transaction at a time: the winner's command is
// latched on grant, mem_resp/mem_rdata are steered back to the winner only,
// and a one-cycle turnaround separates consecutive grants.
// Build option PMEM_ARB_RR_EN: round-robin between the two caches on
// contention. Without it, fixed priority D write > D read > I read.
module pmem_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

`ifdef PMEM_ARB_RR_EN
    localparam bit rr_en = 1'b1;
`else
    localparam bit rr_en = 1'b0;
`endif

    state_t state;
    grant_t last_grant;
    logic   i_req;
    logic   d_req;
    logic   grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Winner selection for the IDLE cycle: D unless round-robin says it is I's turn.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        grant_d = 1'b0;
        if (d_req) begin
            if (!i_req || !rr_en) begin
                grant_d = 1'b1;
            end else begin
                grant_d = (last_grant == GRANT_I);
            end
        end
    end

    // Arbitration FSM; the mem_* command outputs are the latched command registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // Writeback before refill when the D-cache raises both.
                        state       <= SERVE_D;
                        last_grant  <= GRANT_D;
                        mem_address <= d_pmem_address;
                        mem_write   <= d_pmem_write;
                        mem_read    <= ~d_pmem_write;
                        mem_wdata   <= d_pmem_write ? d_pmem_wdata : '0;
                    end else if (i_req) begin
                        state       <= SERVE_I;
                        last_grant  <= GRANT_I;
                        mem_address <= i_pmem_address;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Command stays frozen until memory completes; clearing it keeps DONE/IDLE quiet.
                    if (mem_resp) begin
                        state       <= DONE;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        mem_address <= '0;
                        mem_wdata   <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion steering: only the current winner sees mem_resp, and only while serving.
    always_comb begin
        i_pmem_resp  = (state == SERVE_I) && mem_resp;
        d_pmem_resp  = (state == SERVE_D) && mem_resp;
        i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
        d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed scenarios followed by randomized
// traffic from two cache agents and a memory with random latency and stray
// responses, compared against a transaction-level reference model.
module tb_pmem_arbiter;

    localparam int SL = 256;
    localparam int SA = 32;

`ifdef PMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [SA-1:0] i_pmem_address;
    logic [SL-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [SA-1:0] d_pmem_address;
    logic [SL-1:0] d_pmem_wdata;
    logic [SL-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [SA-1:0] mem_address;
    logic [SL-1:0] mem_wdata;
    logic [SL-1:0] mem_rdata;
    logic          mem_resp;

    int checks = 0;
    int errors = 0;
    int d_resp_cnt = 0;

    pmem_arbiter #(.s_line(SL), .s_addr(SA)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (d_pmem_resp === 1'b1) d_resp_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [SL-1:0] got, input logic [SL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SL-1:0] rand_line();
        logic [SL-1:0] v;
        v = '0;
        for (int k = 0; k < SL / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        d_pmem_address = '0; d_pmem_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_op"}, {mem_read, mem_write}, 2'b00);
        check({tag, "_resp"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
        check({tag, "_addr"}, mem_address, '0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        check("reset_wdata", mem_wdata, '0);
    endtask

    task automatic expect_cmd(input string tag, input bit rd, input bit wr, input logic [SA-1:0] a);
        check({tag, "_op"}, {mem_read, mem_write}, {rd, wr});
        check({tag, "_addr"}, mem_address, a);
    endtask

    // Starts at the negedge of the first command cycle; memory answers lat cycles later.
    task automatic finish_txn(input string tag, input int lat, input bit to_d, input bit wr,
                              input logic [SA-1:0] a, input logic [SL-1:0] wd, input bit scramble);
        logic [SL-1:0] line;
        for (int k = 1; k < lat; k++) begin
            tick();
            if (scramble) begin
                i_pmem_address = $urandom();
                d_pmem_address = $urandom();
                d_pmem_wdata   = rand_line();
            end
            @(negedge clk);
            expect_cmd({tag, "_hold"}, !wr, wr, a);
            if (wr) check({tag, "_hold_wdata"}, mem_wdata, wd);
            check({tag, "_early_resp"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
        end
        tick();
        line = rand_line();
        mem_rdata = line;
        mem_resp = 1'b1;
        @(negedge clk);
        check({tag, "_resp"}, {i_pmem_resp, d_pmem_resp}, {!to_d, to_d});
        if (to_d) check({tag, "_d_rdata"}, d_pmem_rdata, line);
        else      check({tag, "_i_rdata"}, i_pmem_rdata, line);
    endtask

    logic [SL-1:0] pat_a5;
    logic [SA-1:0] ia;
    logic [SA-1:0] da;
    bit            exp_d;
    int            cnt0;

    // Random-phase agent, memory and model state
    bit            i_busy, d_busy, i_seen, d_seen, cmd_seen, resp_driven;
    int            mem_lat;
    int            m_owner;
    bit            m_cool, m_last_d, m_wr, m_take_d, m_ir, m_dr;
    logic [SA-1:0] m_addr;
    logic [SL-1:0] m_wdata;

    initial begin
        rst = 1'b0;
        clear_inputs();
        pat_a5 = {32{8'hA5}};
        do_reset();

        // 1: I read at 0x40, response after 5 cycles
        tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h40;
        @(negedge clk); check_quiet("t1_idle");
        tick(); @(negedge clk); expect_cmd("t1_cmd", 1'b1, 1'b0, 32'h40);
        finish_txn("t1", 5, 1'b0, 1'b0, 32'h40, '0, 1'b0);
        tick(); mem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk); check_quiet("t1_done");
        tick(); @(negedge clk); check_quiet("t1_back_idle");

        // 2: D writeback at 0x80, latched data survives input changes
        tick(); d_pmem_write = 1'b1; d_pmem_address = 32'h80; d_pmem_wdata = pat_a5;
        @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t2_cmd", 1'b0, 1'b1, 32'h80);
        check("t2_wdata", mem_wdata, pat_a5);
        finish_txn("t2", 3, 1'b1, 1'b1, 32'h80, pat_a5, 1'b1);
        tick(); mem_resp = 1'b0; d_pmem_write = 1'b0;
        @(negedge clk); check_quiet("t2_done"); check("t2_done_wdata", mem_wdata, '0);
        tick(); @(negedge clk); check_quiet("t2_idle");

        // 3: contention from reset: D first, then I after DONE + IDLE gap
        do_reset();
        tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h200;
        d_pmem_read = 1'b1; d_pmem_address = 32'h300;
        @(negedge clk); check_quiet("t3_idle");
        tick(); @(negedge clk); expect_cmd("t3_first_d", 1'b1, 1'b0, 32'h300);
        finish_txn("t3_d", 2, 1'b1, 1'b0, 32'h300, '0, 1'b0);
        tick(); mem_resp = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk); check_quiet("t3_gap_done");
        tick(); @(negedge clk); check_quiet("t3_gap_idle");
        tick(); @(negedge clk); expect_cmd("t3_then_i", 1'b1, 1'b0, 32'h200);
        finish_txn("t3_i", 2, 1'b0, 1'b0, 32'h200, '0, 1'b0);
        // Both caches keep requesting: fixed priority starves I, round-robin alternates D, I, D, I
        tick(); mem_resp = 1'b0;
        ia = 32'h1000; da = 32'h2000;
        i_pmem_address = ia; d_pmem_read = 1'b1; d_pmem_address = da;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            exp_d = RR ? (g % 2 == 0) : 1'b1;
            tick(); @(negedge clk);
            tick(); @(negedge clk);
            expect_cmd($sformatf("t3_contend%0d", g), 1'b1, 1'b0, exp_d ? da : ia);
            finish_txn($sformatf("t3_contend%0d", g), 2, exp_d, 1'b0, exp_d ? da : ia, '0, 1'b0);
            tick(); mem_resp = 1'b0;
            if (exp_d) begin da = da + 32'h20; d_pmem_address = da; end
            else begin ia = ia + 32'h20; i_pmem_address = ia; end
            @(negedge clk);
        end
        tick(); i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk);
        tick(); @(negedge clk); check_quiet("t3_drained");

        // 4: D read and write together: write first, then read, two responses
        cnt0 = d_resp_cnt;
        tick(); d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h100; d_pmem_wdata = pat_a5;
        @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t4_wb", 1'b0, 1'b1, 32'h100);
        finish_txn("t4_wb", 3, 1'b1, 1'b1, 32'h100, pat_a5, 1'b0);
        tick(); mem_resp = 1'b0; d_pmem_write = 1'b0;
        @(negedge clk);
        tick(); @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t4_refill", 1'b1, 1'b0, 32'h100);
        finish_txn("t4_refill", 2, 1'b1, 1'b0, 32'h100, '0, 1'b0);
        tick(); mem_resp = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin tick(); @(negedge clk); end
        check("t4_resp_pulses", d_resp_cnt - cnt0, 2);

        // 5: reset mid-SERVE_D, then a stray mem_resp
        tick(); d_pmem_read = 1'b1; d_pmem_address = 32'h180;
        @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t5_cmd", 1'b1, 1'b0, 32'h180);
        tick(); @(negedge clk);
        tick(); rst = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk);
        tick(); rst = 1'b1; mem_resp = 1'b1; mem_rdata = rand_line();
        @(negedge clk); check_quiet("t5_after_reset");
        tick(); mem_resp = 1'b0;
        @(negedge clk); check_quiet("t5_stays_idle");
        tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h1C0;
        @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t5_regrant", 1'b1, 1'b0, 32'h1C0);
        finish_txn("t5_regrant", 1, 1'b0, 1'b0, 32'h1C0, '0, 1'b0);
        tick(); mem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);

        // 6: I address wanders during SERVE_I; mem_address must not
        tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h400;
        @(negedge clk);
        tick(); @(negedge clk); expect_cmd("t6_cmd", 1'b1, 1'b0, 32'h400);
        finish_txn("t6", 4, 1'b0, 1'b0, 32'h400, '0, 1'b1);
        tick(); mem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        i_busy = 0; d_busy = 0; i_seen = 0; d_seen = 0; cmd_seen = 0; resp_driven = 0;
        mem_lat = -1;
        m_owner = 0; m_cool = 0; m_last_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (i_seen) begin i_busy = 0; i_pmem_read = 1'b0; end
            if (!i_busy && $urandom_range(0, 3) == 0) begin
                i_busy = 1; i_pmem_read = 1'b1;
                i_pmem_address = $urandom() & 32'hFFFF_FFE0;
            end
            if (d_seen) begin d_busy = 0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
            if (!d_busy && $urandom_range(0, 3) == 0) begin
                d_busy = 1;
                d_pmem_write = $urandom_range(0, 1) == 1;
                d_pmem_read = !d_pmem_write;
                d_pmem_address = $urandom() & 32'hFFFF_FFE0;
                d_pmem_wdata = rand_line();
            end
            if (cmd_seen && !resp_driven) begin
                if (mem_lat < 0) mem_lat = $urandom_range(0, 4);
                if (mem_lat == 0) begin mem_resp = 1'b1; mem_lat = -1; end
                else begin mem_lat--; mem_resp = 1'b0; end
            end else begin
                mem_lat = -1;
                mem_resp = $urandom_range(0, 5) == 0;
            end
            mem_rdata = rand_line();
            @(negedge clk);

            check("rnd_read", mem_read, (m_owner != 0) && !m_wr);
            check("rnd_write", mem_write, (m_owner != 0) && m_wr);
            check("rnd_addr", mem_address, (m_owner != 0) ? m_addr : '0);
            if (m_owner != 0 && m_wr) check("rnd_wdata", mem_wdata, m_wdata);
            check("rnd_i_resp", i_pmem_resp, (m_owner == 1) && mem_resp);
            check("rnd_d_resp", d_pmem_resp, (m_owner == 2) && mem_resp);
            if (m_owner == 1 && mem_resp) check("rnd_i_rdata", i_pmem_rdata, mem_rdata);
            if (m_owner == 2 && mem_resp) check("rnd_d_rdata", d_pmem_rdata, mem_rdata);

            i_seen = i_pmem_resp; d_seen = d_pmem_resp;
            cmd_seen = mem_read | mem_write; resp_driven = mem_resp;

            if (m_owner != 0) begin
                if (mem_resp) begin m_owner = 0; m_cool = 1; end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                m_ir = i_pmem_read;
                m_dr = d_pmem_read | d_pmem_write;
                if (m_ir || m_dr) begin
                    m_take_d = m_dr && (!m_ir || !RR || !m_last_d);
                    m_last_d = m_take_d;
                    m_owner  = m_take_d ? 2 : 1;
                    m_wr     = m_take_d && d_pmem_write;
                    m_addr   = m_take_d ? d_pmem_address : i_pmem_address;
                    m_wdata  = d_pmem_wdata;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
